nird_code_builder: RTL and testbench

Parametrised successor of the NIRD ring-difference bit stage. It compares pairs of ring sums (S_a vs S_b), optionally with a programmable threshold, and serially packs NUM_CMP comparison bits into one descriptor code word per pixel. It sits after the ring-sum accumulators and feeds the descriptor/histogram stage. Each per-comparison bit is also exposed, registered, so legacy single-bit consumers keep working.

---
 rtl/nird_code_builder_if.sv | 34 +++
 rtl/nird_code_builder.sv | 94 +++++++++
 tb/tb_nird_code_builder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/nird_code_builder_if.sv
// nird_code_builder_if: sample/config inputs and bit/code outputs of the
// NIRD ring-difference code builder.
//   master : the upstream producer (drives samples and config, observes results)
//   slave  : the code builder itself
// Signals:
//   start_i, valid_i, S_a_i, S_b_i, mode_i, th_i       -> builder
//   bit_o, bit_valid_o, code_o, done_o, busy_o, abort_o <- builder
interface nird_code_builder_if #(
  parameter int WIDTH   = 24,
  parameter int NUM_CMP = 8
);
  logic               start_i;
  logic               valid_i;
  logic [WIDTH-1:0]   S_a_i;
  logic [WIDTH-1:0]   S_b_i;
  logic               mode_i;
  logic [WIDTH-1:0]   th_i;
  logic               bit_o;
  logic               bit_valid_o;
  logic [NUM_CMP-1:0] code_o;
  logic               done_o;
  logic               busy_o;
  logic               abort_o;

  modport master (
    output start_i, valid_i, S_a_i, S_b_i, mode_i, th_i,
    input  bit_o, bit_valid_o, code_o, done_o, busy_o, abort_o
  );

  modport slave (
    input  start_i, valid_i, S_a_i, S_b_i, mode_i, th_i,
    output bit_o, bit_valid_o, code_o, done_o, busy_o, abort_o
  );
endinterface

// File: rtl/nird_code_builder.sv
// nird_code_builder: compares ring sums S_a vs S_b (optionally against S_b+th)
// and packs NUM_CMP comparison bits, MSB first, into one descriptor word.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - nird_code_builder_if.slave (samples/config in, bit/code/status out)
module nird_code_builder #(
  parameter int WIDTH   = 24,
  parameter int NUM_CMP = 8,
  parameter int CNT_W   = $clog2(NUM_CMP)
) (
  input logic               clk,
  input logic               rst,
  nird_code_builder_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CMP - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  // Holds the NUM_CMP-1 earlier bits; the final bit is appended on completion.
  logic [NUM_CMP-2:0] shreg;
  logic               mode_q;
  logic [WIDTH-1:0]   th_q;

  logic               first;
  logic               mode_eff;
  logic [WIDTH-1:0]   th_eff;
  logic [WIDTH:0]     b_plus_th;
  logic               cmp;

  // The first sample of a word compares with the live config, which is also
  // latched for the remaining samples of that word.
  always_comb begin
    first     = bus.start_i || (state == IDLE);
    mode_eff  = first ? bus.mode_i : mode_q;
    th_eff    = first ? bus.th_i   : th_q;
    b_plus_th = {1'b0, bus.S_b_i} + {1'b0, th_eff};
    cmp       = '0;
    if (mode_eff) cmp = ({1'b0, bus.S_a_i} >= b_plus_th);
    else          cmp = (bus.S_a_i >= bus.S_b_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      shreg           <= '0;
      mode_q          <= '0;
      th_q            <= '0;
      bus.bit_o       <= '0;
      bus.bit_valid_o <= '0;
      bus.code_o      <= '0;
      bus.done_o      <= '0;
      bus.busy_o      <= '0;
      bus.abort_o     <= '0;
    end else begin
      bus.done_o      <= '0;
      bus.abort_o     <= '0;
      bus.bit_valid_o <= bus.valid_i;
      if (bus.start_i && (state == ACCUM)) bus.abort_o <= '1;

      if (bus.valid_i) begin
        bus.bit_o <= cmp;
        if (first) begin
          mode_q     <= bus.mode_i;
          th_q       <= bus.th_i;
          shreg      <= (NUM_CMP-1)'(cmp);
          count      <= CNT_W'(1);
          state      <= ACCUM;
          bus.busy_o <= '1;
        end else if (count == LAST) begin
          bus.code_o <= {shreg, cmp};
          bus.done_o <= '1;
          shreg      <= '0;
          count      <= '0;
          state      <= IDLE;
          bus.busy_o <= '0;
        end else begin
          shreg <= {shreg[NUM_CMP-3:0], cmp};
          count <= count + CNT_W'(1);
        end
      end else if (bus.start_i) begin
        shreg      <= '0;
        count      <= '0;
        state      <= IDLE;
        bus.busy_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nird_code_builder.sv
module tb_nird_code_builder;
  localparam int W = 24;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nird_code_builder_if #(.WIDTH(W), .NUM_CMP(N)) bus ();

  nird_code_builder #(.WIDTH(W), .NUM_CMP(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // scoreboard
  logic         bitq[$];
  logic [N-1:0] codeq[$];

  // reference model state
  int           m_cnt;
  logic [N-1:0] m_word;
  logic         m_mode;
  logic [W-1:0] m_th;
  logic [N-1:0] held_code;
  logic         e_bv, e_done, e_abort, e_busy;
  int           n_done;

  typedef struct {
    logic         st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] t;
    int           eb;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_bit(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic m, input logic [W-1:0] t);
    logic [W:0] lim;
    lim = {1'b0, b} + {1'b0, t};
    if (m) return ({1'b0, a} >= lim);
    return (a >= b);
  endfunction

  task automatic check_outputs();
    logic         eb;
    logic [N-1:0] ec;
    chk("bit_valid", 32'(bus.bit_valid_o), 32'(e_bv));
    if (bus.bit_valid_o === 1'b1) begin
      if (bitq.size() == 0) chk("bit_queue_empty", 32'(1), 32'(0));
      else begin
        eb = bitq.pop_front();
        chk("bit", 32'(bus.bit_o), 32'(eb));
      end
    end
    chk("done", 32'(bus.done_o), 32'(e_done));
    if (bus.done_o === 1'b1) begin
      n_done++;
      if (codeq.size() == 0) chk("code_queue_empty", 32'(1), 32'(0));
      else begin
        ec = codeq.pop_front();
        held_code = ec;
        chk("code", 32'(bus.code_o), 32'(ec));
      end
    end else begin
      chk("code_hold", 32'(bus.code_o), 32'(held_code));
    end
    chk("abort", 32'(bus.abort_o), 32'(e_abort));
    chk("busy", 32'(bus.busy_o), 32'(e_busy));
  endtask

  // One cycle: check what the previous cycle's inputs produced, then drive new
  // inputs and record what they should produce. eb<0 selects the model bit.
  task automatic step(input logic st, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic m, input logic [W-1:0] t,
                      input int eb);
    logic bt;
    @(negedge clk);
    check_outputs();
    bus.start_i = st; bus.valid_i = v;
    bus.S_a_i = a; bus.S_b_i = b; bus.mode_i = m; bus.th_i = t;
    e_bv = v; e_done = 1'b0;
    e_abort = st && (m_cnt != 0);
    if (v) begin
      if (st || m_cnt == 0) begin
        m_mode = m; m_th = t;
      end
      bt = (eb < 0) ? model_bit(a, b, m_mode, m_th) : eb[0];
      bitq.push_back(bt);
      if (st || m_cnt == 0) begin
        m_word = N'(bt);
        m_cnt = 1;
      end else begin
        m_word = {m_word[N-2:0], bt};
        m_cnt++;
        if (m_cnt == N) begin
          codeq.push_back(m_word);
          e_done = 1'b1;
          m_cnt = 0;
        end
      end
    end else if (st) begin
      m_cnt = 0;
    end
    e_busy = (m_cnt != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, -1);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_word = '0; m_mode = 1'b0; m_th = '0; held_code = '0;
    e_bv = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bit"}, 32'(bus.bit_o), 32'(0));
    chk({tag, "_bit_valid"}, 32'(bus.bit_valid_o), 32'(0));
    chk({tag, "_code"}, 32'(bus.code_o), 32'(0));
    chk({tag, "_done"}, 32'(bus.done_o), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'(0));
    chk({tag, "_abort"}, 32'(bus.abort_o), 32'(0));
  endtask

  initial begin
    int d0;
    bus.start_i = 1'b0; bus.valid_i = 1'b0; bus.S_a_i = '0; bus.S_b_i = '0;
    bus.mode_i = 1'b0; bus.th_i = '0;
    n_done = 0;
    model_reset();

    // mode 0 word: expected 1011_0101
    tbl[0]  = '{1'b1, 24'd100, 24'd50,  1'b0, 24'd0, 1};
    tbl[1]  = '{1'b0, 24'd100, 24'd150, 1'b0, 24'd0, 0};
    tbl[2]  = '{1'b0, 24'd100, 24'd100, 1'b0, 24'd0, 1};
    tbl[3]  = '{1'b0, 24'd100, 24'd0,   1'b0, 24'd0, 1};
    tbl[4]  = '{1'b0, 24'd100, 24'd200, 1'b0, 24'd0, 0};
    tbl[5]  = '{1'b0, 24'd100, 24'd99,  1'b0, 24'd0, 1};
    tbl[6]  = '{1'b0, 24'd100, 24'd101, 1'b0, 24'd0, 0};
    tbl[7]  = '{1'b0, 24'd100, 24'd100, 1'b0, 24'd0, 1};
    // mode 1 th=10 latched; later mode_i/th_i changes must be ignored
    tbl[8]  = '{1'b1, 24'd110, 24'd100, 1'b1, 24'd10,  1};
    tbl[9]  = '{1'b0, 24'd109, 24'd100, 1'b1, 24'd10,  0};
    tbl[10] = '{1'b0, 24'd105, 24'd100, 1'b0, 24'd0,   0};
    tbl[11] = '{1'b0, 24'd120, 24'd100, 1'b0, 24'd0,   1};
    tbl[12] = '{1'b0, 24'hFFFFFF, 24'hFFFFF8, 1'b0, 24'd16, 0};
    tbl[13] = '{1'b0, 24'd50,  24'd60,  1'b1, 24'd0,   0};
    tbl[14] = '{1'b0, 24'd200, 24'd100, 1'b1, 24'd200, 1};
    tbl[15] = '{1'b0, 24'd111, 24'd100, 1'b1, 24'd10,  1};
    // mode 1 th=16, overflow of S_b+th must not wrap
    tbl[16] = '{1'b1, 24'hFFFFFF, 24'hFFFFF8, 1'b1, 24'd16, 0};
    tbl[17] = '{1'b0, 24'hFFFFFF, 24'hFFFFF0, 1'b0, 24'd0,  0};
    tbl[18] = '{1'b0, 24'hFFFFFF, 24'hFFFFEF, 1'b1, 24'd0,  1};
    tbl[19] = '{1'b0, 24'd5,   24'd5,   1'b0, 24'd0, 0};
    tbl[20] = '{1'b0, 24'd21,  24'd5,   1'b0, 24'd0, 1};
    tbl[21] = '{1'b0, 24'd0,   24'd0,   1'b1, 24'd0, 0};
    tbl[22] = '{1'b0, 24'd40,  24'd0,   1'b1, 24'd0, 1};
    tbl[23] = '{1'b0, 24'd16,  24'd0,   1'b0, 24'd0, 1};

    rst = 1'b1;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // three back-to-back words from the table
    for (int i = 0; i < 24; i++)
      step(tbl[i].st, 1'b1, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].t, tbl[i].eb);
    idle(2);
    chk("table_done_count", 32'(n_done), 32'(3));

    // async reset mid-word at count=3
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'd7, 24'(i * 5), 1'b0, '0, -1);
    idle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bitq.delete(); codeq.delete();
    d0 = n_done;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 24'd30, 24'(i * 8), 1'b0, '0, -1);
    idle(1);
    chk("post_reset_done", 32'(n_done - d0), 32'(1));

    // abort: 5 samples then restart; word = start sample + 7
    d0 = n_done;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'd9, 24'(i * 4), 1'b0, '0, -1);
    step(1'b1, 1'b1, 24'd3, 24'd1, 1'b1, 24'd1, -1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 24'(i * 3), 24'd4, 1'b0, 24'd9, -1);
    idle(1);
    chk("abort_done_count", 32'(n_done - d0), 32'(1));

    // start_i without valid_i: clears partial word, aborts
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'd1, 24'd0, 1'b0, '0, -1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, -1);
    // start_i in IDLE: no abort
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, -1);
    idle(1);

    // random stalls across 3 words; no gap at word boundaries
    d0 = n_done;
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < N; s++) begin
        if (s != 0) idle(int'($urandom_range(0, 2)));
        step(1'b0, 1'b1, 24'($urandom_range(0, 300)), 24'($urandom_range(0, 300)),
             1'($urandom_range(0, 1)), 24'($urandom_range(0, 60)), -1);
      end
    end
    idle(2);
    chk("stall_done_count", 32'(n_done - d0), 32'(3));
    chk("bitq_drained", 32'(bitq.size()), 32'(0));
    chk("codeq_drained", 32'(codeq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
